// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional build macro: IMEM_LOADER_VERIFY_EN adds a read-back verify pass
// (states VRD and VCMP) after every word write.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WE_ALL     = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_LOADER_VERIFY_EN
    VRD,
    VCMP,
`endif
    DONE
  } state_e;

  // True when a word index falls inside an instruction memory of depth words.
  function automatic logic word_in_range(input logic [29:0] word_idx,
                                         input int unsigned depth);
    return 32'(word_idx) < depth;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
// word_full_o flags the transfer that completes the word, so the loader can
// schedule the write for the very next cycle.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;

  // Next-state: place the incoming byte in lane byte_cnt; the counter wraps after lane 3.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clr_i) begin
      byte_cnt_d = '0;
    end else if (push_i) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = data_i;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  // Byte counter and word register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = push_i && (byte_cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream, packs it into words and
// writes them through the debug port while holding the CPU stalled.
// Optional build macro: IMEM_LOADER_VERIFY_EN (read back and compare each word).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] base_addr,
  input  logic [15:0] len_words,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] A2,
  output logic [31:0] WD2,
  output logic [3:0]  WE2,
  input  logic [31:0] RD2,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [15:0] len_q;
  logic [15:0] word_cnt_q;
  logic        error_q;

  logic        push;
  logic        start_acc;
  logic        word_full;
  logic [31:0] word;
  logic        addr_ok;
  logic        last_word;
  logic        unused_bits;

  assign push      = (state_q == RECV) && in_valid;
  assign start_acc = (state_q == IDLE) && start && !abort;
  assign addr_ok   = word_in_range(addr_q[31:2], DEPTH_WORDS);
  assign last_word = (word_cnt_q + 16'd1) == len_q;

`ifdef IMEM_LOADER_VERIFY_EN
  assign unused_bits = ^base_addr[1:0];
`else
  assign unused_bits = ^{RD2, base_addr[1:0]};
`endif

  byte_packer u_packer (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (start_acc),
    .push_i      (push),
    .data_i      (in_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  // Load sequencer: state, write address, word counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      error_q    <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            error_q    <= 1'b0;
            addr_q     <= {base_addr[31:2], 2'b00};
            len_q      <= len_words;
            word_cnt_q <= '0;
            state_q    <= (len_words == '0) ? DONE : RECV;
          end
        end
        RECV: begin
          if (word_full) state_q <= WRITE;
        end
        WRITE: begin
          if (!addr_ok) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end else begin
`ifdef IMEM_LOADER_VERIFY_EN
            state_q <= VRD;
`else
            word_cnt_q <= word_cnt_q + 16'd1;
            addr_q     <= addr_q + 32'd4;
            state_q    <= last_word ? DONE : RECV;
`endif
          end
        end
`ifdef IMEM_LOADER_VERIFY_EN
        VRD: state_q <= VCMP;
        VCMP: begin
          if (RD2 != word) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end else begin
            word_cnt_q <= word_cnt_q + 16'd1;
            addr_q     <= addr_q + 32'd4;
            state_q    <= last_word ? DONE : RECV;
          end
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Port decode from the registered state; abort gates the write strobe immediately.
  always_comb begin
    in_ready = (state_q == RECV);
    busy     = (state_q != IDLE);
    cpu_hold = busy;
    done     = (state_q == DONE);
    error    = error_q;
    A2       = '0;
    WD2      = '0;
    WE2      = '0;
    case (state_q)
      WRITE: begin
        A2  = addr_q;
        WD2 = word;
        if (addr_ok && !abort) WE2 = WE_ALL;
      end
`ifdef IMEM_LOADER_VERIFY_EN
      VRD: A2 = addr_q;
`endif
      default: ;
    endcase
  end

endmodule
